// File: rtl/interboard_rx_arbiter_if.sv
// Receive-FIFO / router-ingress bundle for the interboard RX arbiter.
// master = arbiter side, slave = FIFO/router side.
interface interboard_rx_arbiter_if #(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 11,
  parameter int USEDW_W = 8
);
  logic [N_IN-1:0]       in_empty;
  logic [N_IN*WIDTH-1:0] in_q;
  logic [N_IN-1:0]       in_rdreq;
  logic [USEDW_W-1:0]    out_wrusedw;
  logic [WIDTH-1:0]      out_data;
  logic                  out_wrreq;
  logic [N_IN-1:0]       grant;
  logic                  busy;

  modport master (
    input  in_empty,
    input  in_q,
    input  out_wrusedw,
    output in_rdreq,
    output out_data,
    output out_wrreq,
    output grant,
    output busy
  );

  modport slave (
    output in_empty,
    output in_q,
    output out_wrusedw,
    input  in_rdreq,
    input  out_data,
    input  out_wrreq,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/interboard_rx_arbiter.sv
// Packet-atomic round-robin drain of N interboard RX FIFOs
// into the router ingress FIFO, throttled on its fill level.
module interboard_rx_arbiter #(
  parameter int N_IN       = 4,
  parameter int WIDTH      = 11,
  parameter int PKT_WORDS  = 2,
  parameter int USEDW_W    = 8,
  parameter int STOP_LEVEL = 240
) (
  input  logic                   clk,
  input  logic                   reset_n,
  interboard_rx_arbiter_if.master bus
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t             r_state;
  logic [N_IN-1:0]    r_grant;
  logic               r_busy;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rd_d;
  logic [IDX_W-1:0]   r_idx_d;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_wrreq;

  logic               w_found;
  logic [IDX_W-1:0]   w_next;
  logic               w_ok;
  logic               w_last;
  logic [N_IN-1:0]    w_rdreq;

  // Descending scan so the nearest input after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int k = N_IN; k >= 1; k--) begin
      if (!bus.in_empty[(int'(r_last) + k) % N_IN]) begin
        w_found = 1'b1;
        w_next  = IDX_W'((int'(r_last) + k) % N_IN);
      end
    end
  end

  always_comb begin
    w_ok = (r_state == S_XFER)
        && !bus.in_empty[r_gidx]
        && (bus.out_wrusedw < USEDW_W'(STOP_LEVEL));
    w_last  = w_ok && (r_cnt == CNT_W'(PKT_WORDS - 1));
    w_rdreq = '0;
    if (w_ok) w_rdreq[r_gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_gidx  <= '0;
      r_last  <= IDX_W'(N_IN - 1);
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_XFER;
            r_grant <= N_IN'(1) << w_next;
            r_gidx  <= w_next;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_XFER: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_gidx;
            r_cnt   <= '0;
          end else if (w_ok) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO q is valid the cycle after rdreq; capture it one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_d      <= 1'b0;
      r_idx_d     <= '0;
      r_out_data  <= '0;
      r_out_wrreq <= 1'b0;
    end else begin
      r_rd_d  <= |w_rdreq;
      r_idx_d <= r_gidx;
      if (r_rd_d) begin
        r_out_data  <= bus.in_q[r_idx_d*WIDTH +: WIDTH];
        r_out_wrreq <= 1'b1;
      end else begin
        r_out_wrreq <= 1'b0;
      end
    end
  end

  assign bus.in_rdreq  = w_rdreq;
  assign bus.out_data  = r_out_data;
  assign bus.out_wrreq = r_out_wrreq;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_interboard_rx_arbiter.sv
// Directed bench for interboard_rx_arbiter with a
// behavioural normal-mode FIFO model per input.
module tb_interboard_rx_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  interboard_rx_arbiter_if #(
    .N_IN(4), .WIDTH(11), .USEDW_W(8)
  ) ifc ();

  interboard_rx_arbiter #(
    .N_IN(4), .WIDTH(11), .PKT_WORDS(2),
    .USEDW_W(8), .STOP_LEVEL(240)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  logic [10:0] mem [4][32];
  int          wp [4];
  int          rp [4];
  logic [10:0] q_r [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ifc.in_rdreq[i]) begin
        q_r[i] <= mem[i][rp[i] % 32];
        rp[i]  <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    ifc.in_empty = '0;
    ifc.in_q     = '0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_empty[i]       = (wp[i] == rp[i]);
      ifc.in_q[i*11 +: 11]  = q_r[i];
    end
  end

  logic [10:0] obs[$];
  int viol = 0;

  always @(negedge clk) begin
    if (ifc.out_wrreq) obs.push_back(ifc.out_data);
    if ((ifc.in_rdreq & ifc.in_empty) != 4'b0
        || $countones(ifc.in_rdreq) > 1) viol++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int s, input logic [10:0] w);
    mem[s][wp[s] % 32] = w;
    wp[s] = wp[s] + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int bad;
  logic [10:0] exp_w;
  logic [10:0] t5_exp [6];

  initial begin
    ifc.out_wrusedw = '0;
    reset_n = 1'b0;
    tick(2);

    // reset state, then a quiet idle stretch
    chk("rst_wrreq", 32'(ifc.out_wrreq), 0);
    chk("rst_data", 32'(ifc.out_data), 0);
    chk("rst_grant", 32'(ifc.grant), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_rdreq", 32'(ifc.in_rdreq), 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (ifc.in_rdreq != 0 || ifc.grant != 0
          || ifc.busy || ifc.out_wrreq) bad++;
    end
    chk("idle20", 32'(bad), 0);

    // single packet on input 2, cycle by cycle
    push(2, 11'h155);
    push(2, 11'h2AA);
    tick();
    chk("t2_grant", 32'(ifc.grant), 32'b0100);
    chk("t2_busy", 32'(ifc.busy), 1);
    chk("t2_rd1", 32'(ifc.in_rdreq), 32'b0100);
    tick();
    chk("t2_rd2", 32'(ifc.in_rdreq), 32'b0100);
    chk("t2_wr_early", 32'(ifc.out_wrreq), 0);
    tick();
    chk("t2_busy_off", 32'(ifc.busy), 0);
    chk("t2_grant_off", 32'(ifc.grant), 0);
    chk("t2_rd_off", 32'(ifc.in_rdreq), 0);
    chk("t2_wr1", 32'(ifc.out_wrreq), 1);
    chk("t2_d1", 32'(ifc.out_data), 32'h155);
    tick();
    chk("t2_wr2", 32'(ifc.out_wrreq), 1);
    chk("t2_d2", 32'(ifc.out_data), 32'h2AA);
    tick();
    chk("t2_wr_end", 32'(ifc.out_wrreq), 0);

    // round robin over 12 packets
    do_reset();
    obs.delete();
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 4; s++) begin
        push(s, 11'((s << 8) | (p << 4)));
        push(s, 11'((s << 8) | (p << 4) | 1));
      end
    end
    for (int k = 0; k < 400 && obs.size() < 24; k++) tick();
    tick(6);
    chk("t3_count", 32'(obs.size()), 24);
    for (int k = 0; k < 24; k++) begin
      exp_w = 11'((((k / 2) % 4) << 8) | ((k / 8) << 4) | (k % 2));
      if (k < obs.size())
        chk($sformatf("t3_w%0d", k), 32'(obs[k]), 32'(exp_w));
    end

    // threshold stall on input 1
    obs.delete();
    push(1, 11'h1A0);
    push(1, 11'h1A1);
    tick();
    chk("t4_grant", 32'(ifc.grant), 32'b0010);
    chk("t4_rd1", 32'(ifc.in_rdreq), 32'b0010);
    tick();
    ifc.out_wrusedw = 8'd240;
    #1;
    chk("t4_block", 32'(ifc.in_rdreq), 0);
    bad = 0;
    repeat (5) begin
      tick();
      if (ifc.in_rdreq != 0 || ifc.grant != 4'b0010) bad++;
    end
    chk("t4_hold", 32'(bad), 0);
    ifc.out_wrusedw = 8'd239;
    #1;
    chk("t4_resume", 32'(ifc.in_rdreq), 32'b0010);
    tick(6);
    chk("t4_count", 32'(obs.size()), 2);
    if (obs.size() == 2) begin
      chk("t4_w0", 32'(obs[0]), 32'h1A0);
      chk("t4_w1", 32'(obs[1]), 32'h1A1);
    end
    chk("t4_idle", 32'(ifc.busy), 0);

    // empty stall on input 0 ignores other requesters
    ifc.out_wrusedw = '0;
    obs.delete();
    push(0, 11'h0A1);
    tick();
    chk("t5_grant", 32'(ifc.grant), 32'b0001);
    tick();
    push(1, 11'h1B0);
    push(1, 11'h1B1);
    push(3, 11'h3B0);
    push(3, 11'h3B1);
    bad = 0;
    repeat (10) begin
      tick();
      if (ifc.in_rdreq != 0 || ifc.grant != 4'b0001) bad++;
    end
    chk("t5_hold", 32'(bad), 0);
    push(0, 11'h0A2);
    for (int k = 0; k < 20
         && (ifc.grant == 0 || ifc.grant == 4'b0001); k++) tick();
    chk("t5_next", 32'(ifc.grant), 32'b0010);
    tick(12);
    t5_exp = '{11'h0A1, 11'h0A2, 11'h1B0, 11'h1B1, 11'h3B0, 11'h3B1};
    chk("t5_count", 32'(obs.size()), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < obs.size())
        chk($sformatf("t5_w%0d", k), 32'(obs[k]), 32'(t5_exp[k]));
    end

    // reset with a word in flight
    obs.delete();
    push(2, 11'h2C0);
    push(2, 11'h2C1);
    tick();
    chk("t6_grant2", 32'(ifc.grant), 32'b0100);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_wrreq", 32'(ifc.out_wrreq), 0);
    chk("t6_grant", 32'(ifc.grant), 0);
    chk("t6_busy", 32'(ifc.busy), 0);
    chk("t6_data", 32'(ifc.out_data), 0);
    chk("t6_rdreq", 32'(ifc.in_rdreq), 0);
    tick();
    push(0, 11'h0D0);
    push(0, 11'h0D1);
    push(1, 11'h1D0);
    push(1, 11'h1D1);
    push(3, 11'h3D0);
    push(3, 11'h3D1);
    reset_n = 1'b1;
    tick();
    chk("t6_first", 32'(ifc.grant), 32'b0001);
    chk("t6_noflight", 32'(obs.size()), 0);
    tick(40);
    chk("rd_rules", 32'(viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
